// File: rtl/boton_acondicionador_pkg.sv
// Shared types and constants for the button conditioner: channel FSM states
// and the channel index assignment used by the top level.
package boton_acondicionador_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_e;

  localparam int SLEEP  = 0;
  localparam int AWAKE  = 1;
  localparam int FEED   = 2;
  localparam int NUM_CH = 3;

endpackage

// File: rtl/boton_debounce.sv
// One button channel: 2-flop synchronizer, polarity normalisation, debounce
// FSM with stability counter, registered level and press strobe.
module boton_debounce
  import boton_acondicionador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw,
  output logic       level,
  output logic       press,
  output btn_state_e state_o
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic          RAW_IDLE = (RAW_ACTIVE_LOW != 0);

  logic          sync1_q, sync2_q;
  logic          in_on;
  btn_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;

  // The synchronizer idles at the released pin value, so reset never looks like a press.
  assign in_on = sync2_q ^ RAW_IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
      state_q <= RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RELEASED: begin
        if (in_on) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!in_on) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!in_on) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (in_on) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Level and strobe are decoded from the next state so they register on the FSM edge.
  always_comb begin
    level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d = level_d && !level_q;
  end

  assign level   = level_q;
  assign press   = press_q;
  assign state_o = state_q;

endmodule

// File: rtl/boton_acondicionador.sv
// Button conditioner top: three debounced channels, priority arbitration of
// the press strobes and the sleep+awake hold detector for game restart.
module boton_acondicionador
  import boton_acondicionador_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int HOLD_CYCLES     = 1000,
  parameter int RAW_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_sleep,
  input  logic       raw_awake,
  input  logic       raw_feed,
  output logic       botonSleep,
  output logic       botonAwake,
  output logic       botonFeed,
  output logic       pulse_sleep,
  output logic       pulse_awake,
  output logic       pulse_feed,
  output logic       rst_game,
  output logic [5:0] dbg_state
);

  localparam int            HW       = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

  logic [NUM_CH-1:0] raw_vec, level_vec, press_vec;
  btn_state_e        ch_state [NUM_CH];

  assign raw_vec[SLEEP] = raw_sleep;
  assign raw_vec[AWAKE] = raw_awake;
  assign raw_vec[FEED]  = raw_feed;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    boton_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RAW_ACTIVE_LOW (RAW_ACTIVE_LOW)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .raw    (raw_vec[i]),
      .level  (level_vec[i]),
      .press  (press_vec[i]),
      .state_o(ch_state[i])
    );
    assign dbg_state[2*i +: 2] = ch_state[i];
  end

  assign botonSleep = level_vec[SLEEP];
  assign botonAwake = level_vec[AWAKE];
  assign botonFeed  = level_vec[FEED];

  // Losing strobes are dropped: awake beats sleep beats feed.
  assign pulse_awake = press_vec[AWAKE];
  assign pulse_sleep = press_vec[SLEEP] && !press_vec[AWAKE];
  assign pulse_feed  = press_vec[FEED] && !press_vec[AWAKE] && !press_vec[SLEEP];

  logic          both_held;
  logic [HW-1:0] hold_q, hold_d;
  logic          armed_q, armed_d;
  logic          rst_game_q, rst_game_d;

  assign both_held = level_vec[SLEEP] && level_vec[AWAKE];

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= '0;
      armed_q    <= 1'b1;
      rst_game_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      armed_q    <= armed_d;
      rst_game_q <= rst_game_d;
    end
  end

  // Once fired, the detector stays disarmed until both levels are back to 0.
  always_comb begin
    hold_d = '0;
    if (both_held) begin
      hold_d = (hold_q == HOLD_MAX) ? HOLD_MAX : hold_q + HW'(1);
    end
    rst_game_d = armed_q && (hold_d == HOLD_MAX);
    armed_d    = armed_q;
    if (rst_game_d) begin
      armed_d = 1'b0;
    end else if (!level_vec[SLEEP] && !level_vec[AWAKE]) begin
      armed_d = 1'b1;
    end
  end

  assign rst_game = rst_game_q;

endmodule

// File: tb/tb_boton_acondicionador.sv
// Directed bench for boton_acondicionador with DEBOUNCE_CYCLES=4,
// HOLD_CYCLES=8, active-low raw pins.
module tb_boton_acondicionador;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       raw_sleep = 1'b1;
  logic       raw_awake = 1'b1;
  logic       raw_feed  = 1'b1;
  logic       botonSleep, botonAwake, botonFeed;
  logic       pulse_sleep, pulse_awake, pulse_feed;
  logic       rst_game;
  logic [5:0] dbg_state;

  int checks = 0;
  int errors = 0;

  boton_acondicionador #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (8),
    .RAW_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raw_sleep  (raw_sleep),
    .raw_awake  (raw_awake),
    .raw_feed   (raw_feed),
    .botonSleep (botonSleep),
    .botonAwake (botonAwake),
    .botonFeed  (botonFeed),
    .pulse_sleep(pulse_sleep),
    .pulse_awake(pulse_awake),
    .pulse_feed (pulse_feed),
    .rst_game   (rst_game),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Output vector order: {lvl sleep, lvl awake, lvl feed, p sleep, p awake, p feed, rst_game}
  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] raw;   // {sleep, awake, feed}, 0 = pressed
    int         n;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [6:0] outs();
    return {botonSleep, botonAwake, botonFeed, pulse_sleep, pulse_awake, pulse_feed, rst_game};
  endfunction

  // Driver tasks: inputs change on the falling edge, outputs sampled there too.
  task automatic drive(input logic r, input logic [2:0] raw);
    rst       = r;
    raw_sleep = raw[2];
    raw_awake = raw[1];
    raw_feed  = raw[0];
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Runs n cycles, counting rst_game pulses and the cycle of the first one.
  task automatic run_count(input int n, output int cnt, output int first_k);
    cnt = 0;
    first_k = -1;
    for (int k = 1; k <= n; k++) begin
      step(1);
      if (rst_game) begin
        cnt++;
        if (first_k < 0) first_k = k;
      end
    end
  endtask

  initial begin
    int cnt, first_k;

    tbl.push_back('{"reset",          1'b1, 3'b111, 2, 7'b0000000});
    tbl.push_back('{"sleep_pre",      1'b0, 3'b011, 6, 7'b0000000});
    tbl.push_back('{"sleep_rise",     1'b0, 3'b011, 1, 7'b1001000});
    tbl.push_back('{"sleep_hold",     1'b0, 3'b011, 1, 7'b1000000});
    tbl.push_back('{"sleep_rel_pre",  1'b0, 3'b111, 6, 7'b1000000});
    tbl.push_back('{"sleep_rel_fall", 1'b0, 3'b111, 1, 7'b0000000});
    tbl.push_back('{"simul_pre",      1'b0, 3'b100, 6, 7'b0000000});
    tbl.push_back('{"simul_rise",     1'b0, 3'b100, 1, 7'b0110100});
    tbl.push_back('{"simul_hold",     1'b0, 3'b100, 1, 7'b0110000});
    tbl.push_back('{"simul_rel",      1'b0, 3'b111, 8, 7'b0000000});
    tbl.push_back('{"midpress_start", 1'b0, 3'b011, 4, 7'b0000000});
    tbl.push_back('{"midpress_rst",   1'b1, 3'b011, 2, 7'b0000000});
    tbl.push_back('{"after_rst_pre",  1'b0, 3'b011, 6, 7'b0000000});
    tbl.push_back('{"after_rst_rise", 1'b0, 3'b011, 1, 7'b1001000});
    tbl.push_back('{"after_rst_rel",  1'b0, 3'b111, 8, 7'b0000000});

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].raw);
      step(tbl[i].n);
      check(tbl[i].name, outs(), tbl[i].exp);
    end

    // Glitch on feed: 3 cycles low must never reach the level or the strobe.
    drive(1'b0, 3'b110);
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("glitch_low", {botonFeed, pulse_feed}, 7'b0);
    end
    drive(1'b0, 3'b111);
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("glitch_after", {botonFeed, pulse_feed}, 7'b0);
    end

    // Release produces no strobe at any cycle.
    drive(1'b0, 3'b110);
    step(8);
    check("feed_pressed", outs(), 7'b0010000);
    drive(1'b0, 3'b111);
    for (int k = 0; k < 8; k++) begin
      step(1);
      check("release_no_pulse", {pulse_sleep, pulse_awake, pulse_feed}, 7'b0);
    end
    check("feed_released", outs(), 7'b0000000);

    // Combo hold: sleep+awake pressed together, awake wins the strobe.
    drive(1'b0, 3'b001);
    step(6);
    check("combo_pre", outs(), 7'b0000000);
    step(1);
    check("combo_rise", outs(), 7'b1100100);
    run_count(20, cnt, first_k);
    check("combo_rst_cnt", 7'(cnt), 7'd1);
    check("combo_rst_at", 7'(first_k), 7'd8);

    // Releasing only awake must not re-arm.
    drive(1'b0, 3'b011);
    run_count(10, cnt, first_k);
    check("awake_rel_rst", 7'(cnt), 7'd0);
    check("awake_rel_lvl", outs(), 7'b1000000);
    drive(1'b0, 3'b001);
    run_count(26, cnt, first_k);
    check("rehold_no_rearm", 7'(cnt), 7'd0);
    check("rehold_lvl", outs(), 7'b1100000);

    // Both released: re-arms and fires again.
    drive(1'b0, 3'b111);
    run_count(12, cnt, first_k);
    check("both_rel_rst", 7'(cnt), 7'd0);
    check("both_rel_lvl", outs(), 7'b0000000);
    drive(1'b0, 3'b001);
    step(7);
    check("combo2_rise", outs(), 7'b1100100);
    run_count(20, cnt, first_k);
    check("combo2_rst_cnt", 7'(cnt), 7'd1);
    check("combo2_rst_at", 7'(first_k), 7'd8);

    // Final report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
